tap_controller: RTL and testbench

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_controller.sv | 172 +++++++++++++++++
 tb/tb_tap_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// JTAG TAP controller: 16-state TAP FSM, 4-instruction IR decode and the
// IDCODE / GETTEST (BSR config) / RUNBIST (result readout) / BYPASS data paths.
module tap_controller #(
  parameter int          IR_WIDTH = 4,
  parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
  input  logic        TCK,
  input  logic        TRST,
  input  logic        TMS,
  input  logic        TDI,
  output logic        TDO,
  output logic        TLR,
  output logic        UPDATEDR,
  output logic        RUNBIST_SELECT,
  output logic        GETTEST_SELECT,
  output logic [9:0]  BSR,
  input  logic [15:0] BIST_DATA
);

  // state       | meaning
  // S_TLR       | test-logic-reset, IR forced to IDCODE, BSR cleared
  // S_RTI       | run-test/idle
  // S_SEL_*     | select DR / IR scan branch
  // S_CAP_*     | parallel load of the selected shift register
  // S_SHIFT_*   | serial shift, TDI into MSB, LSB on TDO
  // S_EXIT1/2_* | leave shift, go to pause or update
  // S_PAUSE_*   | hold shift contents
  // S_UPDATE_*  | shifted value has been committed
  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR, S_UPDATE_DR,
    S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPDATE_IR
  } state_t;

  localparam logic [IR_WIDTH-1:0] INS_IDCODE  = IR_WIDTH'(4'b0001);
  localparam logic [IR_WIDTH-1:0] INS_GETTEST = IR_WIDTH'(4'b0010);
  localparam logic [IR_WIDTH-1:0] INS_RUNBIST = IR_WIDTH'(4'b0011);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(4'b0101);

  typedef enum logic [1:0] {P_ID, P_GT, P_RB, P_BY} path_t;

  state_t              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [9:0]          gt_sr_q, gt_sr_d;
  logic [15:0]         rb_sr_q, rb_sr_d;
  logic                by_sr_q, by_sr_d;
  logic [9:0]          bsr_q, bsr_d;
  logic                gt_sel_q, gt_sel_d;
  logic                rb_sel_q, rb_sel_d;
  path_t               path;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q  <= S_TLR;
      ir_sr_q  <= '0;
      instr_q  <= INS_IDCODE;
      id_sr_q  <= '0;
      gt_sr_q  <= '0;
      rb_sr_q  <= '0;
      by_sr_q  <= 1'b0;
      bsr_q    <= '0;
      gt_sel_q <= 1'b0;
      rb_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_sr_q  <= ir_sr_d;
      instr_q  <= instr_d;
      id_sr_q  <= id_sr_d;
      gt_sr_q  <= gt_sr_d;
      rb_sr_q  <= rb_sr_d;
      by_sr_q  <= by_sr_d;
      bsr_q    <= bsr_d;
      gt_sel_q <= gt_sel_d;
      rb_sel_q <= rb_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:       state_d = TMS ? S_TLR      : S_RTI;
      S_RTI:       state_d = TMS ? S_SEL_DR   : S_RTI;
      S_SEL_DR:    state_d = TMS ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:    state_d = TMS ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR:  state_d = TMS ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR:  state_d = TMS ? S_UPDATE_DR : S_PAUSE_DR;
      S_PAUSE_DR:  state_d = TMS ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR:  state_d = TMS ? S_UPDATE_DR : S_SHIFT_DR;
      S_UPDATE_DR: state_d = TMS ? S_SEL_DR   : S_RTI;
      S_SEL_IR:    state_d = TMS ? S_TLR      : S_CAP_IR;
      S_CAP_IR:    state_d = TMS ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR:  state_d = TMS ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR:  state_d = TMS ? S_UPDATE_IR : S_PAUSE_IR;
      S_PAUSE_IR:  state_d = TMS ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR:  state_d = TMS ? S_UPDATE_IR : S_SHIFT_IR;
      S_UPDATE_IR: state_d = TMS ? S_SEL_DR   : S_RTI;
      default:     state_d = S_TLR;
    endcase
  end

  // Any code other than the three defined instructions falls through to bypass.
  always_comb begin
    if (instr_q == INS_IDCODE)       path = P_ID;
    else if (instr_q == INS_GETTEST) path = P_GT;
    else if (instr_q == INS_RUNBIST) path = P_RB;
    else                             path = P_BY;
  end

  always_comb begin
    ir_sr_d = ir_sr_q;
    instr_d = instr_q;
    id_sr_d = id_sr_q;
    gt_sr_d = gt_sr_q;
    rb_sr_d = rb_sr_q;
    by_sr_d = by_sr_q;
    bsr_d   = bsr_q;
    case (state_q)
      S_TLR: begin
        instr_d = INS_IDCODE;
        bsr_d   = '0;
      end
      S_CAP_IR:   ir_sr_d = IR_CAPTURE;
      S_SHIFT_IR: ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
      S_CAP_DR: begin
        case (path)
          P_ID:    id_sr_d = IDCODE;
          P_GT:    gt_sr_d = bsr_q;
          P_RB:    rb_sr_d = BIST_DATA;
          default: by_sr_d = 1'b0;
        endcase
      end
      S_SHIFT_DR: begin
        case (path)
          P_ID:    id_sr_d = {TDI, id_sr_q[31:1]};
          P_GT:    gt_sr_d = {TDI, gt_sr_q[9:1]};
          P_RB:    rb_sr_d = {TDI, rb_sr_q[15:1]};
          default: by_sr_d = TDI;
        endcase
      end
      default: ;
    endcase
    if (state_d == S_UPDATE_IR) instr_d = ir_sr_q;
    if (state_d == S_UPDATE_DR && path == P_GT) bsr_d = gt_sr_q;
  end

  // Selects are registered from the next instruction so they never glitch.
  assign gt_sel_d = (instr_d == INS_GETTEST);
  assign rb_sel_d = (instr_d == INS_RUNBIST);

  always_comb begin
    TDO = 1'b0;
    if (state_q == S_SHIFT_IR) begin
      TDO = ir_sr_q[0];
    end else if (state_q == S_SHIFT_DR) begin
      case (path)
        P_ID:    TDO = id_sr_q[0];
        P_GT:    TDO = gt_sr_q[0];
        P_RB:    TDO = rb_sr_q[0];
        default: TDO = by_sr_q;
      endcase
    end
  end

  assign TLR            = (state_q == S_TLR);
  assign UPDATEDR       = (state_q == S_UPDATE_DR);
  assign GETTEST_SELECT = gt_sel_q;
  assign RUNBIST_SELECT = rb_sel_q;
  assign BSR            = bsr_q;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: directed JTAG scans push expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_tap_controller;

  logic        TCK = 1'b0;
  logic        TRST, TMS, TDI;
  logic        TDO, TLR, UPDATEDR, RUNBIST_SELECT, GETTEST_SELECT;
  logic [9:0]  BSR;
  logic [15:0] BIST_DATA;

  tap_controller #(.IR_WIDTH(4), .IDCODE(32'h1000_0001)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TLR(TLR),
    .UPDATEDR(UPDATEDR), .RUNBIST_SELECT(RUNBIST_SELECT),
    .GETTEST_SELECT(GETTEST_SELECT), .BSR(BSR), .BIST_DATA(BIST_DATA)
  );

  always #5 TCK = ~TCK;

  localparam int SEL_TDO = 0, SEL_TLR = 1, SEL_UPD = 2, SEL_BSR = 3, SEL_GT = 4, SEL_RB = 5;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic drain_req = 1'b0;
  logic drain_ack = 1'b0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  always @(posedge TCK) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      SEL_TDO: return 32'(TDO);
      SEL_TLR: return 32'(TLR);
      SEL_UPD: return 32'(UPDATEDR);
      SEL_BSR: return 32'(BSR);
      SEL_GT:  return 32'(GETTEST_SELECT);
      default: return 32'(RUNBIST_SELECT);
    endcase
  endfunction

  always @(negedge TCK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      mon_e   = sb.pop_front();
      mon_act = pick(mon_e.sel);
      n_tests++;
      if (mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", mon_e.name, mon_e.cyc, mon_act, mon_e.exp);
      end
    end
    if (drain_req && !drain_ack) begin
      n_tests++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      drain_ack = 1'b1;
    end
  end

  task automatic expect_sig(int sel, logic [31:0] val, string name);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.sel  = sel;
    e.exp  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(logic tms, logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // From RTI: scan code into IR, end back in RTI.
  task automatic load_ir(logic [3:0] code, logic gt, logic rb);
    logic [3:0] cap;
    cap = 4'b0101;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      expect_sig(SEL_TDO, 32'(cap[i]), "ir_capture_out");
      step(i == 3, code[i]);
    end
    step(1, 0);
    expect_sig(SEL_GT, 32'(gt), "gettest_select");
    expect_sig(SEL_RB, 32'(rb), "runbist_select");
    step(0, 0);
  endtask

  // From RTI: full DR scan with update, end back in RTI.
  task automatic shift_dr(int len, logic [31:0] din, logic [31:0] dout,
                          logic [9:0] bsr_pre, logic [9:0] bsr_post, string tag);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < len; i++) begin
      expect_sig(SEL_TDO, 32'(dout[i]), tag);
      step(i == len - 1, din[i]);
    end
    expect_sig(SEL_BSR, 32'(bsr_pre), "bsr_before_update");
    expect_sig(SEL_UPD, 0, "updatedr_exit1");
    step(1, 0);
    expect_sig(SEL_UPD, 1, "updatedr_pulse");
    expect_sig(SEL_BSR, 32'(bsr_post), "bsr_in_update");
    step(0, 0);
    expect_sig(SEL_UPD, 0, "updatedr_after");
    expect_sig(SEL_TDO, 0, "tdo_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, w;
    v = 32'(10'b1010110011);
    w = 32'(10'b0101001100);
    TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; BIST_DATA = 16'h0;
    @(posedge TCK); #1;
    @(posedge TCK); #1;
    expect_sig(SEL_TLR, 1, "rst_tlr");
    expect_sig(SEL_BSR, 0, "rst_bsr");
    expect_sig(SEL_UPD, 0, "rst_upd");
    expect_sig(SEL_GT,  0, "rst_gt");
    expect_sig(SEL_RB,  0, "rst_rb");
    expect_sig(SEL_TDO, 0, "rst_tdo");
    TRST = 1'b0;

    // IDCODE readout straight after reset
    step(0, 0);
    expect_sig(SEL_TLR, 0, "rti_tlr");
    shift_dr(32, 32'h0, 32'h1000_0001, 10'h0, 10'h0, "idcode_out");

    // TMS=1 from RTI reaches TLR by the 3rd edge and stays
    for (int k = 1; k <= 5; k++) begin
      step(1, 0);
      expect_sig(SEL_TLR, 32'(k >= 3), "tms_hold_tlr");
    end
    step(0, 0);

    // GETTEST: BSR load, then a paused scan that must not lose bits
    load_ir(4'b0010, 1, 0);
    shift_dr(10, v, 32'h0, 10'h0, v[9:0], "gettest_out0");
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) begin
      expect_sig(SEL_TDO, 32'(v[i]), "pause_scan_out");
      step(i == 4, w[i]);
    end
    step(0, 0);
    expect_sig(SEL_BSR, 32'(v[9:0]), "bsr_in_pause");
    step(0, 0); step(1, 0); step(0, 0);
    for (int i = 5; i < 10; i++) begin
      expect_sig(SEL_TDO, 32'(v[i]), "pause_scan_out");
      step(i == 9, w[i]);
    end
    expect_sig(SEL_BSR, 32'(v[9:0]), "bsr_before_update");
    step(1, 0);
    expect_sig(SEL_UPD, 1, "updatedr_pulse");
    expect_sig(SEL_BSR, 32'(w[9:0]), "bsr_after_pause_scan");
    step(0, 0);

    // RUNBIST readout, BSR untouched
    load_ir(4'b0011, 0, 1);
    BIST_DATA = 16'hFFFF;
    shift_dr(16, 32'h0, 32'h0000_FFFF, w[9:0], w[9:0], "runbist_ones");
    BIST_DATA = 16'h5A3C;
    shift_dr(16, 32'h1234, 32'h0000_5A3C, w[9:0], w[9:0], "runbist_data");

    // BYPASS and an undefined code: one-cycle delay, first bit 0
    load_ir(4'b1111, 0, 0);
    shift_dr(8, 32'hB2, 32'h64, w[9:0], w[9:0], "bypass_out");
    load_ir(4'b0111, 0, 0);
    shift_dr(8, 32'h5D, 32'hBA, w[9:0], w[9:0], "undef_bypass_out");

    // TMS=1 from PAUSE_DR: passes UPDATE_DR, TLR on 5th edge, BSR cleared one edge later
    load_ir(4'b0010, 1, 0);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_sig(SEL_TDO, 32'(w[i]), "gettest_capture_out");
      step(i == 2, 1);
    end
    step(0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, 0);
      expect_sig(SEL_TLR, 32'(k == 5), "pause_to_tlr");
    end
    expect_sig(SEL_BSR, 32'h3A9, "bsr_update_on_way_out");
    step(1, 0);
    expect_sig(SEL_TLR, 1, "tlr_stays");
    expect_sig(SEL_BSR, 0, "bsr_cleared_in_tlr");
    expect_sig(SEL_GT,  0, "gt_cleared_in_tlr");
    step(0, 0);

    // TRST in the middle of SHIFT_DR aborts with no update
    load_ir(4'b0010, 1, 0);
    shift_dr(10, v, 32'h0, 10'h0, v[9:0], "gettest_out1");
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 1); step(0, 1);
    TRST = 1'b1;
    step(1, 0);
    TRST = 1'b0;
    expect_sig(SEL_TLR, 1, "trst_tlr");
    expect_sig(SEL_BSR, 0, "trst_bsr");
    expect_sig(SEL_UPD, 0, "trst_upd");
    expect_sig(SEL_GT,  0, "trst_gt");
    expect_sig(SEL_TDO, 0, "trst_tdo");
    step(1, 0);
    expect_sig(SEL_TLR, 1, "trst_tlr_next");
    expect_sig(SEL_UPD, 0, "trst_upd_next");
    expect_sig(SEL_BSR, 0, "trst_bsr_next");
    step(0, 0);
    step(0, 0);

    drain_req = 1'b1;
    for (int k = 0; k < 4 && !drain_ack; k++) @(posedge TCK);
    #1;
    if (!drain_ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got no ack, expected ack");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
